// File: rtl/parallel_to_serial.sv
// 10-bit symbol serializer: small FIFO in front of an LSB-first shift register,
// with K28.5 comma alignment on enable and comma fill when the FIFO runs dry.
module parallel_to_serial #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALIGN_CNT  = 2
) (
    input  logic       Recovered_Bit_Clk,
    input  logic       Rst_n,
    input  logic [9:0] Data_in,
    input  logic       Data_valid,
    output logic       Data_ready,
    input  logic       Tx_en,
    input  logic       TxPolarity,
    output logic       Ser_out,
    output logic       Sym_start,
    output logic       Comma_sent,
    output logic       Underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ALIGN_CNT + 1);
    localparam logic [9:0] COMMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMMA_POS = 10'b1100000101;

    typedef enum logic [1:0] {S_OFF, S_ALIGN, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          push, pop;
    logic [9:0]    shift_reg, shift_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] align_cnt, align_cnt_nxt;
    logic          comma_tgl, comma_tgl_nxt;
    logic          comma_sel;
    logic          load_comma;
    logic          underflow_nxt;
    logic          boundary;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign Data_ready = !fifo_full;
    assign push       = Data_valid && !fifo_full;
    assign boundary   = (bit_cnt == 4'd9);

    assign Ser_out    = (state != S_OFF) && (shift_reg[0] ^ TxPolarity);
    assign Sym_start  = (state != S_OFF) && (bit_cnt == 4'd0);
    assign Comma_sent = Sym_start && ((shift_reg == COMMA_NEG) || (shift_reg == COMMA_POS));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        bit_cnt_nxt   = bit_cnt;
        align_cnt_nxt = align_cnt;
        comma_tgl_nxt = comma_tgl;
        underflow_nxt = 1'b0;
        pop           = 1'b0;
        load_comma    = 1'b0;
        comma_sel     = comma_tgl;

        unique case (state)
            S_OFF: begin
                if (Tx_en) begin
                    state_nxt     = S_ALIGN;
                    load_comma    = 1'b1;
                    comma_sel     = 1'b0;
                    align_cnt_nxt = CW'(1);
                    bit_cnt_nxt   = 4'd0;
                end
            end
            S_ALIGN, S_RUN: begin
                if (!boundary) begin
                    shift_nxt   = {1'b0, shift_reg[9:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end else begin
                    bit_cnt_nxt = 4'd0;
                    if (!Tx_en) begin
                        state_nxt = S_OFF;
                        shift_nxt = '0;
                    end else if ((state == S_ALIGN) && (align_cnt != CW'(ALIGN_CNT))) begin
                        load_comma    = 1'b1;
                        align_cnt_nxt = align_cnt + 1'b1;
                    end else begin
                        // The last alignment boundary already behaves as a RUN boundary.
                        state_nxt = S_RUN;
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shift_nxt = fifo_mem[rd_ptr[AW-1:0]];
                        end else begin
                            load_comma    = 1'b1;
                            underflow_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = S_OFF;
        endcase

        if (load_comma) begin
            shift_nxt     = comma_sel ? COMMA_POS : COMMA_NEG;
            comma_tgl_nxt = !comma_sel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_OFF;
            shift_reg <= '0;
            bit_cnt   <= '0;
            align_cnt <= '0;
            comma_tgl <= 1'b0;
            Underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            align_cnt <= align_cnt_nxt;
            comma_tgl <= comma_tgl_nxt;
            Underflow <= underflow_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the cleared pointers alone mark every entry invalid.
    always_ff @(posedge Recovered_Bit_Clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= Data_in;
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial: a symbol-level reference model queues
// expected symbols, and a monitor compares every serialized symbol as it appears.
module tb_parallel_to_serial;
    localparam int FIFO_DEPTH = 4;
    localparam int ALIGN_CNT  = 2;
    localparam logic [9:0] COMMA_A = 10'b0011111010;
    localparam logic [9:0] COMMA_B = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] Data_in = '0;
    logic       Data_valid = 1'b0;
    logic       Data_ready;
    logic       Tx_en = 1'b0;
    logic       TxPolarity = 1'b0;
    logic       Ser_out, Sym_start, Comma_sent, Underflow;

    parallel_to_serial #(.FIFO_DEPTH(FIFO_DEPTH), .ALIGN_CNT(ALIGN_CNT)) dut (
        .Recovered_Bit_Clk(clk),
        .Rst_n(rst_n),
        .Data_in(Data_in),
        .Data_valid(Data_valid),
        .Data_ready(Data_ready),
        .Tx_en(Tx_en),
        .TxPolarity(TxPolarity),
        .Ser_out(Ser_out),
        .Sym_start(Sym_start),
        .Comma_sent(Comma_sent),
        .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] word;
        logic       comma;
        logic       uf;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference model state: symbol-level view of the transmitter.
    logic [9:0] src_q [$];
    logic [9:0] mq [$];
    exp_t       exp_q [$];
    bit         active, tog, took, m_empty;
    int         pos, commas_left;
    bit         src_random = 1'b0;
    int         src_rate = 4;

    task automatic emit(input logic [9:0] sym, input logic uf);
        exp_t e;
        e.word  = sym ^ {10{TxPolarity}};
        e.comma = (sym == COMMA_A) || (sym == COMMA_B);
        e.uf    = uf;
        exp_q.push_back(e);
    endtask

    task automatic emit_comma(input logic uf);
        logic [9:0] sym;
        sym = tog ? COMMA_B : COMMA_A;
        tog = !tog;
        if (commas_left > 0) commas_left--;
        emit(sym, uf);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            active = 0; pos = 0; commas_left = 0; tog = 0; took = 0;
        end else begin
            m_empty = (mq.size() == 0);
            took    = Data_valid && (mq.size() < FIFO_DEPTH);
            if (!active) begin
                if (Tx_en) begin
                    active = 1; pos = 0; tog = 0; commas_left = ALIGN_CNT;
                    emit_comma(1'b0);
                end
            end else if (pos == 9) begin
                pos = 0;
                if (!Tx_en)               active = 0;
                else if (commas_left > 0) emit_comma(1'b0);
                else if (!m_empty)        emit(mq.pop_front(), 1'b0);
                else                      emit_comma(1'b1);
            end else begin
                pos++;
            end
            if (took) begin
                mq.push_back(Data_in);
                if (src_q.size() > 0) src_q.delete(0);
            end
        end
    end

    // Source: holds a symbol on Data_in until it is taken.
    always @(posedge clk) begin
        #2;
        if (!(Data_valid && !took)) begin
            if (src_q.size() > 0 && (!src_random || $urandom_range(0, 9) < src_rate)) begin
                Data_valid = 1'b1;
                Data_in    = src_q[0];
            end else begin
                Data_valid = 1'b0;
                Data_in    = 10'($urandom);
            end
        end
    end

    // Monitor: collects each serialized symbol and pops its expectation.
    logic [9:0] rx_log [$];
    logic       rx_comma [$];
    int         uf_seen = 0;
    bit         collecting = 0;
    int         nbits = 0;
    logic [9:0] word;
    logic       start_comma;
    exp_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 0;
        end else begin
            check("data_ready", Data_ready, mq.size() < FIFO_DEPTH);
            check("sym_start", Sym_start, active && pos == 0);
            if (!active) check("idle_ser_out", Ser_out, 1'b0);
            if (Underflow) uf_seen++;
            if (Sym_start) begin
                if (collecting) check("symbol_gap_bits", nbits, 10);
                collecting = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_symbol_queue", exp_q.size(), 1);
                end else begin
                    cur = exp_q.pop_front();
                    collecting = 1; nbits = 0; start_comma = Comma_sent;
                    check("comma_sent", Comma_sent, cur.comma);
                    check("underflow", Underflow, cur.uf);
                end
            end else begin
                check("stray_flags", {Comma_sent, Underflow}, 2'b00);
            end
            if (collecting) begin
                word[nbits] = Ser_out;
                nbits++;
                if (nbits == 10) begin
                    check("symbol_bits", word, cur.word);
                    rx_log.push_back(word);
                    rx_comma.push_back(start_comma);
                    collecting = 0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string name, input int idx, input logic [9:0] exp);
        if (rx_log.size() > idx) check(name, rx_log[idx], exp);
        else check({name, "_missing"}, rx_log.size(), idx + 1);
    endtask

    task automatic do_reset();
        Tx_en = 0; Data_valid = 0; src_q.delete(); rst_n = 0;
        #1;
        check("rst_ser_out", Ser_out, 1'b0);
        check("rst_flags", {Sym_start, Comma_sent, Underflow}, 3'b000);
        check("rst_ready", Data_ready, 1'b1);
        cyc(2);
        rst_n = 1;
        cyc(1);
        check("post_rst_outputs", {Ser_out, Sym_start, Comma_sent, Underflow, Data_ready}, 5'b00001);
        rx_log.delete(); rx_comma.delete(); uf_seen = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active && n < 30) begin cyc(1); n++; end
        check("wait_idle_timeout", active, 1'b0);
    endtask

    task automatic wait_rx_pos(input int sz, input int p);
        int n = 0;
        while (!(rx_log.size() == sz && pos == p) && n < 200) begin cyc(1); n++; end
        check("wait_pos_timeout", rx_log.size() == sz && pos == p, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        do_reset();

        // Enabled with no data: two alignment commas, then comma fill with Underflow.
        Tx_en = 1;
        cyc(60);
        check_rx("first_comma", 0, 10'h0FA);
        check_rx("second_comma", 1, 10'h305);
        check_rx("fill_comma", 2, 10'h0FA);
        check("underflow_pulses", uf_seen, 4);
        Tx_en = 0;
        wait_idle();

        // Two data symbols pushed during alignment follow the commas with no gap.
        do_reset();
        Tx_en = 1;
        src_q.push_back(10'h2AA); src_q.push_back(10'h155);
        cyc(45);
        check_rx("data_2aa", 2, 10'h2AA);
        check_rx("data_155", 3, 10'h155);
        if (rx_comma.size() > 3) check("data_not_comma", {rx_comma[2], rx_comma[3]}, 2'b00);
        else check("data_comma_log_missing", rx_comma.size(), 4);
        Tx_en = 0;
        wait_idle();

        // Five back-to-back pushes while off: FIFO fills, fifth is held by the source.
        do_reset();
        for (int i = 1; i <= 5; i++) src_q.push_back(10'(10'h100 + i));
        cyc(10);
        check("full_ready_low", Data_ready, 1'b0);
        check("fifth_held", src_q.size(), 1);
        check("fifth_valid_held", Data_valid, 1'b1);
        check("off_ser_out", Ser_out, 1'b0);
        Tx_en = 1;
        cyc(100);
        check_rx("held_fifth_sent", 6, 10'h105);
        Tx_en = 0;
        wait_idle();

        // Inverted polarity on a data symbol.
        do_reset();
        TxPolarity = 1;
        src_q.push_back(10'h0F0);
        Tx_en = 1;
        cyc(45);
        check_rx("polarity_0f0", 2, 10'h30F);
        Tx_en = 0;
        wait_idle();
        TxPolarity = 0;

        // Tx_en drops at bit 3 of a data symbol: symbol finishes, FIFO keeps its entries.
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(10'(10'h1A0 + i));
        Tx_en = 1;
        wait_rx_pos(2, 3);
        Tx_en = 0;
        wait_idle();
        check_rx("finished_symbol", 2, 10'h1A1);
        for (int i = 1; i <= 3; i++) src_q.push_back(10'(10'h2B0 + i));
        cyc(10);
        check("occupancy_kept", src_q.size(), 2);
        Tx_en = 1;
        cyc(120);
        check_rx("resume_data", 5, 10'h1A2);
        Tx_en = 0;
        wait_idle();

        // Reset at bit 5 with three entries queued: output stops, FIFO discarded.
        do_reset();
        src_q.push_back(10'h011); src_q.push_back(10'h022); src_q.push_back(10'h033);
        Tx_en = 1;
        wait_rx_pos(1, 5);
        rst_n = 0;
        #1;
        check("midsym_rst_ser_out", Ser_out, 1'b0);
        check("midsym_rst_ready", Data_ready, 1'b1);
        Tx_en = 0;
        cyc(2);
        rst_n = 1;
        rx_log.delete(); rx_comma.delete();
        Tx_en = 1;
        cyc(45);
        check_rx("restart_comma", 0, 10'h0FA);
        check_rx("fifo_discarded", 2, 10'h0FA);
        Tx_en = 0;
        wait_idle();

        // Randomized traffic with enable toggling, one segment per polarity.
        do_reset();
        src_random = 1;
        for (int seg = 0; seg < 2; seg++) begin
            TxPolarity = seg[0];
            src_rate   = (seg == 0) ? 4 : 1;
            Tx_en = 1;
            for (int c = 0; c < 1200; c++) begin
                cyc(1);
                if (src_q.size() < 3) src_q.push_back(10'($urandom_range(0, 1023)));
                if ($urandom_range(0, 149) == 0) Tx_en = !Tx_en;
            end
            Tx_en = 0;
            wait_idle();
        end
        cyc(2);
        check("expectations_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
